// File: rtl/atm_transaction_ctrl.sv
// ATM transaction controller: authenticates a card session against the card database,
// executes inquiry/withdraw/deposit on a working balance and strobes commits back.
module atm_transaction_ctrl #(
  parameter int unsigned BalanceWidth  = 20,
  parameter int unsigned MaxAttempts   = 3,
  parameter int unsigned TimeoutCycles = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    card_in_i,
  input  logic                    psw_enter_i,
  input  logic                    op_go_i,
  input  logic [1:0]              op_sel_i,
  input  logic [BalanceWidth-1:0] amount_i,
  input  logic [BalanceWidth-1:0] balance_i,
  input  logic                    wrong_psw_i,
  output logic                    op_done_o,
  output logic [BalanceWidth-1:0] updated_balance_o,
  output logic [BalanceWidth-1:0] disp_balance_o,
  output logic                    err_psw_o,
  output logic                    err_insufficient_o,
  output logic                    err_overflow_o,
  output logic                    eject_o,
  output logic                    card_retained_o,
  output logic                    busy_o
);

  localparam int unsigned AttW = $clog2(MaxAttempts + 1);
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  localparam logic [1:0] OpInquiry  = 2'b00;
  localparam logic [1:0] OpWithdraw = 2'b01;
  localparam logic [1:0] OpDeposit  = 2'b10;
  localparam logic [1:0] OpExit     = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StAuth,
    StCheck,
    StMenu,
    StCommit,
    StEject,
    StLocked
  } state_e;

  state_e                  state_q, state_d;
  logic [BalanceWidth-1:0] work_bal_q, work_bal_d;
  logic [BalanceWidth-1:0] disp_q, disp_d;
  logic [AttW-1:0]         attempts_q, attempts_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic                    err_psw_q, err_psw_d;
  logic                    err_insuf_q, err_insuf_d;
  logic                    err_ovf_q, err_ovf_d;
  logic                    eject_q, eject_d;

  logic [BalanceWidth:0]   dep_sum;
  logic [AttW-1:0]         attempts_inc;
  logic                    tmo_expired;

  assign dep_sum      = {1'b0, work_bal_q} + {1'b0, amount_i};
  assign attempts_inc = attempts_q + AttW'(1);
  assign tmo_expired  = (tmo_q == TmoW'(TimeoutCycles - 1));

  always_comb begin
    state_d     = state_q;
    work_bal_d  = work_bal_q;
    disp_d      = disp_q;
    attempts_d  = attempts_q;
    tmo_d       = '0;
    err_psw_d   = 1'b0;
    err_insuf_d = 1'b0;
    err_ovf_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        attempts_d = '0;
        if (card_in_i) state_d = StAuth;
      end
      StAuth: begin
        // Priority: card removal, then timeout, then the password strobe.
        if (!card_in_i) begin
          state_d = StIdle;
        end else if (tmo_expired) begin
          state_d = StEject;
        end else if (psw_enter_i) begin
          state_d = StCheck;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StCheck: begin
        if (!card_in_i) begin
          state_d = StIdle;
        end else if (!wrong_psw_i) begin
          work_bal_d = balance_i;
          disp_d     = balance_i;
          state_d    = StMenu;
        end else begin
          err_psw_d  = 1'b1;
          attempts_d = attempts_inc;
          state_d    = (attempts_inc == AttW'(MaxAttempts)) ? StLocked : StAuth;
        end
      end
      StMenu: begin
        if (!card_in_i) begin
          state_d = StIdle;
        end else if (tmo_expired) begin
          state_d = StEject;
        end else if (op_go_i) begin
          unique case (op_sel_i)
            OpInquiry: disp_d = work_bal_q;
            OpWithdraw: begin
              if (amount_i == '0 || amount_i > work_bal_q) begin
                err_insuf_d = 1'b1;
              end else begin
                work_bal_d = work_bal_q - amount_i;
                state_d    = StCommit;
              end
            end
            OpDeposit: begin
              if (amount_i == '0 || dep_sum[BalanceWidth]) begin
                err_ovf_d = 1'b1;
              end else begin
                work_bal_d = dep_sum[BalanceWidth-1:0];
                state_d    = StCommit;
              end
            end
            OpExit: state_d = StEject;
            default: state_d = StMenu;
          endcase
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StCommit: begin
        // The commit strobe fires even if the card is pulled during this cycle.
        disp_d  = work_bal_q;
        state_d = card_in_i ? StMenu : StIdle;
      end
      StEject: begin
        if (!card_in_i) state_d = StIdle;
      end
      StLocked: begin
        if (!card_in_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    eject_d = (state_d == StEject) && (state_q != StEject);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      work_bal_q  <= '0;
      disp_q      <= '0;
      attempts_q  <= '0;
      tmo_q       <= '0;
      err_psw_q   <= 1'b0;
      err_insuf_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      eject_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_bal_q  <= work_bal_d;
      disp_q      <= disp_d;
      attempts_q  <= attempts_d;
      tmo_q       <= tmo_d;
      err_psw_q   <= err_psw_d;
      err_insuf_q <= err_insuf_d;
      err_ovf_q   <= err_ovf_d;
      eject_q     <= eject_d;
    end
  end

  assign op_done_o          = (state_q == StCommit);
  assign updated_balance_o  = work_bal_q;
  assign disp_balance_o     = disp_q;
  assign err_psw_o          = err_psw_q;
  assign err_insufficient_o = err_insuf_q;
  assign err_overflow_o     = err_ovf_q;
  assign eject_o            = eject_q;
  assign card_retained_o    = (state_q == StLocked);
  assign busy_o             = (state_q != StIdle);

endmodule

// File: tb/tb_atm_transaction_ctrl.sv
// Directed bench for atm_transaction_ctrl: session, arithmetic, lockout, timeout and
// card-removal scenarios with hand-computed expectations.
module tb_atm_transaction_ctrl;

  localparam int unsigned W = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         card_in, psw_enter, op_go, wrong_psw;
  logic [1:0]   op_sel;
  logic [W-1:0] amount, balance;
  logic         op_done, err_psw, err_insufficient, err_overflow, eject, card_retained, busy;
  logic [W-1:0] updated_balance, disp_balance;

  int checks = 0;
  int errors = 0;

  atm_transaction_ctrl #(
    .BalanceWidth (W),
    .MaxAttempts  (3),
    .TimeoutCycles(16)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .card_in_i         (card_in),
    .psw_enter_i       (psw_enter),
    .op_go_i           (op_go),
    .op_sel_i          (op_sel),
    .amount_i          (amount),
    .balance_i         (balance),
    .wrong_psw_i       (wrong_psw),
    .op_done_o         (op_done),
    .updated_balance_o (updated_balance),
    .disp_balance_o    (disp_balance),
    .err_psw_o         (err_psw),
    .err_insufficient_o(err_insufficient),
    .err_overflow_o    (err_overflow),
    .eject_o           (eject),
    .card_retained_o   (card_retained),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Card in, password strobe, database answers good password with the given balance.
  task automatic start_session(input logic [W-1:0] bal);
    card_in = 1'b1;
    tick();
    psw_enter = 1'b1;
    tick();
    psw_enter = 1'b0;
    wrong_psw = 1'b0;
    balance   = bal;
    tick();
  endtask

  task automatic issue_op(input logic [1:0] sel, input logic [W-1:0] amt);
    op_go  = 1'b1;
    op_sel = sel;
    amount = amt;
    tick();
    op_go  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({op_done, err_psw, err_insufficient, err_overflow, eject, card_retained, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {op_done, err_psw, err_insufficient, err_overflow, eject, card_retained, busy});
    end
    checks++;
    if (updated_balance !== '0 || disp_balance !== '0) begin
      errors++;
      $display("FAIL reset_balances got upd=%0d disp=%0d want 0/0", updated_balance, disp_balance);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_good_pin();
    card_in = 1'b1;
    tick();
    // op_go in AUTH must be ignored.
    issue_op(2'b01, 20'd5);
    checks++;
    if (err_insufficient !== 1'b0 || op_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL auth_ignore_op got ins=%b done=%b busy=%b want 0 0 1",
               err_insufficient, op_done, busy);
    end
    psw_enter = 1'b1;
    tick();
    psw_enter = 1'b0;
    wrong_psw = 1'b0;
    balance   = 20'd500;
    tick();
    checks++;
    if (disp_balance !== 20'd500 || updated_balance !== 20'd500) begin
      errors++;
      $display("FAIL good_pin_bal got disp=%0d upd=%0d want 500/500", disp_balance, updated_balance);
    end
    checks++;
    if (op_done !== 1'b0 || err_psw !== 1'b0) begin
      errors++;
      $display("FAIL good_pin_flags got done=%b psw=%b want 0 0", op_done, err_psw);
    end
  endtask

  task automatic test_withdraw();
    issue_op(2'b01, 20'd200);
    checks++;
    if (op_done !== 1'b1 || updated_balance !== 20'd300) begin
      errors++;
      $display("FAIL wd_commit got done=%b upd=%0d want 1/300", op_done, updated_balance);
    end
    tick();
    checks++;
    if (op_done !== 1'b0 || disp_balance !== 20'd300) begin
      errors++;
      $display("FAIL wd_after got done=%b disp=%0d want 0/300", op_done, disp_balance);
    end
    issue_op(2'b01, 20'd400);
    checks++;
    if (err_insufficient !== 1'b1 || op_done !== 1'b0 || updated_balance !== 20'd300) begin
      errors++;
      $display("FAIL wd_insuf got ins=%b done=%b upd=%0d want 1 0 300",
               err_insufficient, op_done, updated_balance);
    end
    tick();
    checks++;
    if (err_insufficient !== 1'b0 || op_done !== 1'b0) begin
      errors++;
      $display("FAIL wd_insuf_pulse got ins=%b done=%b want 0 0", err_insufficient, op_done);
    end
    issue_op(2'b01, 20'd0);
    checks++;
    if (err_insufficient !== 1'b1 || op_done !== 1'b0) begin
      errors++;
      $display("FAIL wd_zero got ins=%b done=%b want 1 0", err_insufficient, op_done);
    end
    tick();
  endtask

  task automatic test_deposit();
    issue_op(2'b10, 20'hFFEC4);
    checks++;
    if (op_done !== 1'b1 || updated_balance !== 20'hFFFF0) begin
      errors++;
      $display("FAIL dep_fill got done=%b upd=%h want 1/ffff0", op_done, updated_balance);
    end
    tick();
    issue_op(2'b10, 20'h00020);
    checks++;
    if (err_overflow !== 1'b1 || op_done !== 1'b0 || updated_balance !== 20'hFFFF0) begin
      errors++;
      $display("FAIL dep_ovf got ovf=%b done=%b upd=%h want 1 0 ffff0",
               err_overflow, op_done, updated_balance);
    end
    tick();
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL dep_ovf_pulse got %b want 0", err_overflow);
    end
    issue_op(2'b10, 20'h0000F);
    checks++;
    if (op_done !== 1'b1 || updated_balance !== 20'hFFFFF || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL dep_max got done=%b upd=%h ovf=%b want 1 fffff 0",
               op_done, updated_balance, err_overflow);
    end
    tick();
    checks++;
    if (op_done !== 1'b0 || disp_balance !== 20'hFFFFF) begin
      errors++;
      $display("FAIL dep_after got done=%b disp=%h want 0/fffff", op_done, disp_balance);
    end
    issue_op(2'b10, 20'd0);
    checks++;
    if (err_overflow !== 1'b1 || err_insufficient !== 1'b0) begin
      errors++;
      $display("FAIL dep_zero got ovf=%b ins=%b want 1 0", err_overflow, err_insufficient);
    end
    issue_op(2'b00, 20'd0);
    checks++;
    if (disp_balance !== 20'hFFFFF || op_done !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL inquiry got disp=%h done=%b ovf=%b want fffff 0 0",
               disp_balance, op_done, err_overflow);
    end
  endtask

  task automatic test_exit();
    issue_op(2'b11, 20'd0);
    checks++;
    if (eject !== 1'b1 || busy !== 1'b1 || op_done !== 1'b0) begin
      errors++;
      $display("FAIL exit_eject got ej=%b busy=%b done=%b want 1 1 0", eject, busy, op_done);
    end
    tick();
    checks++;
    if (eject !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL exit_hold got ej=%b busy=%b want 0 1", eject, busy);
    end
    card_in = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || eject !== 1'b0) begin
      errors++;
      $display("FAIL exit_idle got busy=%b ej=%b want 0 0", busy, eject);
    end
  endtask

  task automatic test_wrong_pins();
    card_in = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      psw_enter = 1'b1;
      tick();
      psw_enter = 1'b0;
      checks++;
      if (err_psw !== 1'b0) begin
        errors++;
        $display("FAIL psw_pulse_low[%0d] got %b want 0", i, err_psw);
      end
      wrong_psw = 1'b1;
      tick();
      wrong_psw = 1'b0;
      checks++;
      if (err_psw !== 1'b1 || card_retained !== (i == 2)) begin
        errors++;
        $display("FAIL psw_wrong[%0d] got err=%b ret=%b want 1 %b", i, err_psw, card_retained,
                 (i == 2));
      end
    end
    repeat (3) tick();
    checks++;
    if (card_retained !== 1'b1 || err_psw !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL locked_hold got ret=%b err=%b busy=%b want 1 0 1", card_retained, err_psw, busy);
    end
    card_in = 1'b0;
    tick();
    checks++;
    if (card_retained !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL locked_release got ret=%b busy=%b want 0 0", card_retained, busy);
    end
    // A fresh session starts with a clean attempt count.
    card_in = 1'b1;
    tick();
    psw_enter = 1'b1;
    tick();
    psw_enter = 1'b0;
    wrong_psw = 1'b1;
    tick();
    wrong_psw = 1'b0;
    checks++;
    if (err_psw !== 1'b1 || card_retained !== 1'b0) begin
      errors++;
      $display("FAIL attempts_cleared got err=%b ret=%b want 1 0", err_psw, card_retained);
    end
    card_in = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || eject !== 1'b0) begin
      errors++;
      $display("FAIL auth_pull got busy=%b ej=%b want 0 0", busy, eject);
    end
  endtask

  task automatic test_timeout();
    start_session(20'd77);
    repeat (15) tick();
    checks++;
    if (eject !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early got ej=%b busy=%b want 0 1", eject, busy);
    end
    tick();
    checks++;
    if (eject !== 1'b1) begin
      errors++;
      $display("FAIL tmo_eject got %b want 1", eject);
    end
    tick();
    checks++;
    if (eject !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_eject_pulse got ej=%b busy=%b want 0 1", eject, busy);
    end
    card_in = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    start_session(20'd500);
    op_go  = 1'b1;
    op_sel = 2'b01;
    amount = 20'd100;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({op_done, eject, busy, err_insufficient} !== 4'b0 || updated_balance !== '0 ||
        disp_balance !== '0) begin
      errors++;
      $display("FAIL rst_mid_async got flags=%b upd=%0d disp=%0d want 0000 0 0",
               {op_done, eject, busy, err_insufficient}, updated_balance, disp_balance);
    end
    tick();
    checks++;
    if (op_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold got done=%b busy=%b want 0 0", op_done, busy);
    end
    op_go   = 1'b0;
    card_in = 1'b0;
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_card_pull();
    start_session(20'd1000);
    card_in = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || eject !== 1'b0 || op_done !== 1'b0) begin
      errors++;
      $display("FAIL menu_pull got busy=%b ej=%b done=%b want 0 0 0", busy, eject, op_done);
    end
    start_session(20'd1000);
    issue_op(2'b01, 20'd1);
    card_in = 1'b0;
    checks++;
    if (op_done !== 1'b1 || updated_balance !== 20'd999) begin
      errors++;
      $display("FAIL commit_pull_done got done=%b upd=%0d want 1/999", op_done, updated_balance);
    end
    tick();
    checks++;
    if (op_done !== 1'b0 || busy !== 1'b0 || eject !== 1'b0) begin
      errors++;
      $display("FAIL commit_pull_idle got done=%b busy=%b ej=%b want 0 0 0", op_done, busy, eject);
    end
  endtask

  initial begin
    card_in   = 1'b0;
    psw_enter = 1'b0;
    op_go     = 1'b0;
    op_sel    = 2'b00;
    amount    = '0;
    balance   = '0;
    wrong_psw = 1'b0;
    test_reset();
    test_good_pin();
    test_withdraw();
    test_deposit();
    test_exit();
    test_wrong_pins();
    test_timeout();
    test_reset_mid();
    test_card_pull();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_transaction_ctrl.md
Name: atm_transaction_ctrl

Overview:
- Transaction controller for the card database block: authenticates the session, runs withdraw/deposit/inquiry, and returns the new balance plus commit strobe.
- Consumes the database's registered balance and wrong_psw; drives op_done and updated_balance back to it.
- Sits between the user-facing keypad/card-reader logic and the card database.
- Owns attempt counting, amount arithmetic, inactivity timeout and card eject/retain.

Parameters:
balance_width, 20, width of balance and amount buses
max_attempts, 3, wrong passwords before card is retained
timeout_cycles, 1000, idle cycles in AUTH/MENU before forced eject

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset: asynchronous, active-low; one clock, clk
card_in  input  1  card present (level, from reader)
psw_enter  input  1  one-cycle pulse: password on database input is stable this cycle
op_go  input  1  one-cycle pulse: execute op_sel
op_sel  input  2  00 inquiry, 01 withdraw, 10 deposit, 11 exit
amount  input  balance_width  transaction amount, sampled on op_go
balance  input  balance_width  balance from database, valid 1 cycle after card_in/password
wrong_psw  input  1  database mismatch flag, reflects password of previous cycle
op_done  output  1  one-cycle commit strobe to database
updated_balance  output  balance_width  working balance presented to database
disp_balance  output  balance_width  balance shown to user
err_psw  output  1  one-cycle pulse per wrong password
err_insufficient  output  1  one-cycle pulse, withdraw rejected
err_overflow  output  1  one-cycle pulse, deposit rejected
eject  output  1  one-cycle pulse, return card
card_retained  output  1  level, card swallowed after max_attempts failures
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (any state, any time): state IDLE; all outputs 0; work_bal, attempt counter, timeout counter cleared. Reset mid-transaction drops the transaction with no op_done.
- States: IDLE, AUTH, CHECK, MENU, COMMIT, EJECT, LOCKED.
- IDLE: card_in high -> AUTH; attempts = 0.
- AUTH: wait for psw_enter -> CHECK.
- CHECK (exactly one cycle, the cycle after psw_enter): sample wrong_psw.
  - 0: work_bal <= balance; disp_balance <= balance -> MENU.
  - 1: err_psw pulse, attempts+1. If attempts reach max_attempts: card_retained=1 -> LOCKED; else -> AUTH.
- MENU: on op_go, decode op_sel.
  - Inquiry: disp_balance <= work_bal, stay in MENU.
  - Withdraw: amount==0 or amount>work_bal -> err_insufficient, stay. Else work_bal <= work_bal-amount -> COMMIT.
  - Deposit: compute a balance_width+1 sum. amount==0 or carry set -> err_overflow, stay. Else work_bal <= sum -> COMMIT.
  - Exit -> EJECT.
- COMMIT (one cycle): op_done=1; updated_balance already equals new work_bal; disp_balance <= work_bal -> MENU. Exactly one op_done per accepted operation.
- updated_balance is continuously driven from work_bal; it changes only on CHECK load or an accepted withdraw/deposit.
- EJECT: eject pulse on entry; wait for card_in low -> IDLE.
- LOCKED: card_retained held high until card_in low -> IDLE, which clears card_retained.
- Card removal: card_in low in AUTH, CHECK or MENU -> IDLE, no op_done, no eject. card_in low in COMMIT: op_done still issues that cycle, then IDLE.
- Timeout: counter clears on entering AUTH/MENU and on any psw_enter/op_go. Reaching timeout_cycles in AUTH or MENU -> EJECT.
- Input priority in same cycle: rst > card_in low > timeout > psw_enter/op_go.
- psw_enter/op_go outside their states are ignored.
- Error flags are single-cycle and mutually exclusive.

Test Plan:
- Good PIN, balance=500: card_in=1, psw_enter, wrong_psw=0 in next cycle -> MENU, disp_balance=500, no op_done.
- Withdraw 200 from 500 -> op_done high for exactly 1 cycle with updated_balance=300, disp_balance=300. Withdraw 400 from 300 -> err_insufficient, no op_done, balance stays 300.
- Deposit near limit: work_bal=0xFFFF0, deposit 0x20 -> err_overflow, no op_done. Deposit 0x0F -> op_done, updated_balance=0xFFFFF.
- Three wrong PINs (wrong_psw=1 in each CHECK) -> three err_psw pulses, then card_retained=1 and LOCKED. card_in=0 -> IDLE with card_retained=0.
- Idle in MENU for timeout_cycles (use 16 in bench) -> eject pulse. card_in=0 -> IDLE. Reset asserted in COMMIT-bound withdraw before COMMIT -> all outputs 0, no op_done.
- Card pulled in MENU and exit (op_sel=11) paths -> card pull: IDLE, no eject; exit: single eject pulse, IDLE after card_in low.
